// File: rtl/i2c_byte_rx_pkg.sv
// i2c_rx_pkg: shared types and constants for the I2C slave byte receiver.
package i2c_rx_pkg;

  localparam int         BIT_CNT_W        = 3;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;

  localparam logic [2:0] ENC_IDLE     = 3'd0;
  localparam logic [2:0] ENC_ADDR     = 3'd1;
  localparam logic [2:0] ENC_ADDR_ACK = 3'd2;
  localparam logic [2:0] ENC_DATA     = 3'd3;
  localparam logic [2:0] ENC_DATA_ACK = 3'd4;
  localparam logic [2:0] ENC_IGNORE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = ENC_IDLE,
    ST_ADDR     = ENC_ADDR,
    ST_ADDR_ACK = ENC_ADDR_ACK,
    ST_DATA     = ENC_DATA,
    ST_DATA_ACK = ENC_DATA_ACK,
    ST_IGNORE   = ENC_IGNORE
  } i2c_rx_state_t;

  // True when the 7 address bits of a received address byte equal dev_addr.
  function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
    return (addr_byte[7:1] == dev_addr);
  endfunction

endpackage

// File: rtl/i2c_byte_rx_if.sv
// i2c_byte_rx_if: I2C pad lines plus the event/byte hand-off to the downstream sequencer.
interface i2c_byte_rx_if;
  logic       sda;
  logic       scl;
  logic       sda_oe;
  logic       start_det;
  logic       stop_det;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rw;
  logic       addr_match;
  logic       busy;
  logic [2:0] state_dbg;

  modport slave (
    input  sda, scl,
    output sda_oe, start_det, stop_det, byte_valid, byte_data,
           rw, addr_match, busy, state_dbg
  );

  modport master (
    output sda, scl,
    input  sda_oe, start_det, stop_det, byte_valid, byte_data,
           rw, addr_match, busy, state_dbg
  );
endinterface

// File: rtl/i2c_byte_rx_line_sync.sv
// i2c_line_sync: synchroniser, optional glitch filter (I2C_GLITCH_FILTER_EN)
// and rise/fall edge detection for one open-drain I2C line.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   synced_s;
  logic                   level_s;
  logic                   prev_r;

  // Metastability chain; resets to the idle-high bus level so no edge is seen on release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], line};
    end
  end

  assign synced_s = sync_r[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic             filt_r;
  logic [CNT_W-1:0] cnt_r;

  // Accept a new level only after it has been stable for FILT_LEN consecutive cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_r <= 1'b1;
      cnt_r  <= '0;
    end else if (synced_s != filt_r) begin
      if (cnt_r == CNT_W'(FILT_LEN - 1)) begin
        filt_r <= synced_s;
        cnt_r  <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign level_s = filt_r;
`else
  assign level_s = synced_s;
`endif

  // One-cycle delayed copy of the conditioned level for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= level_s;
    end
  end

  assign level = level_s;
  assign rise  = level_s & ~prev_r;
  assign fall  = ~level_s & prev_r;

endmodule

// File: rtl/i2c_byte_rx.sv
// i2c_byte_rx: I2C slave receive front end. Detects START/STOP, shifts bytes in
// MSB-first, matches DEV_ADDR, drives the ACK and hands write bytes downstream.
// Optional input glitch filter is enabled with the macro I2C_GLITCH_FILTER_EN.
module i2c_byte_rx
  import i2c_rx_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3
) (
  input  logic           clk,
  input  logic           reset,
  i2c_byte_rx_if.slave   bus
);

  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic start_s, stop_s;
  logic [7:0] byte_s;

  i2c_rx_state_t        state_r, state_nxt_s;
  logic [BIT_CNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]           shreg_r, shreg_nxt_s;
  logic                 ack_phase_r, ack_phase_nxt_s;
  logic                 sda_oe_r, sda_oe_nxt_s;
  logic                 start_det_r, start_det_nxt_s;
  logic                 stop_det_r, stop_det_nxt_s;
  logic                 byte_valid_r, byte_valid_nxt_s;
  logic [7:0]           byte_data_r, byte_data_nxt_s;
  logic                 rw_r, rw_nxt_s;
  logic                 addr_match_r, addr_match_nxt_s;
  logic                 busy_r, busy_nxt_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_sync (
    .clk(clk), .reset(reset), .line(bus.sda),
    .level(sda_lvl_s), .rise(sda_rise_s), .fall(sda_fall_s)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_sync (
    .clk(clk), .reset(reset), .line(bus.scl),
    .level(scl_lvl_s), .rise(scl_rise_s), .fall(scl_fall_s)
  );

  assign start_s = sda_fall_s & scl_lvl_s;
  assign stop_s  = sda_rise_s & scl_lvl_s;
  assign byte_s  = {shreg_r[6:0], sda_lvl_s};

  // Next-state and next-output logic; bus conditions override bit sampling.
  always_comb begin
    state_nxt_s      = state_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    shreg_nxt_s      = shreg_r;
    ack_phase_nxt_s  = ack_phase_r;
    sda_oe_nxt_s     = sda_oe_r;
    start_det_nxt_s  = 1'b0;
    stop_det_nxt_s   = 1'b0;
    byte_valid_nxt_s = 1'b0;
    byte_data_nxt_s  = byte_data_r;
    rw_nxt_s         = rw_r;
    addr_match_nxt_s = addr_match_r;
    busy_nxt_s       = busy_r;

    if (start_s) begin
      start_det_nxt_s  = 1'b1;
      busy_nxt_s       = 1'b1;
      addr_match_nxt_s = 1'b0;
      bit_cnt_nxt_s    = '0;
      sda_oe_nxt_s     = 1'b0;
      ack_phase_nxt_s  = 1'b0;
      state_nxt_s      = ST_ADDR;
    end else if (stop_s) begin
      stop_det_nxt_s   = 1'b1;
      busy_nxt_s       = 1'b0;
      addr_match_nxt_s = 1'b0;
      sda_oe_nxt_s     = 1'b0;
      ack_phase_nxt_s  = 1'b0;
      state_nxt_s      = ST_IDLE;
    end else begin
      case (state_r)
        ST_ADDR, ST_DATA: begin
          if (scl_rise_s) begin
            shreg_nxt_s   = byte_s;
            bit_cnt_nxt_s = bit_cnt_r + BIT_CNT_W'(1);
            if (bit_cnt_r == BIT_CNT_W'(7)) begin
              ack_phase_nxt_s = 1'b0;
              if (state_r == ST_DATA) begin
                byte_data_nxt_s  = byte_s;
                byte_valid_nxt_s = 1'b1;
                state_nxt_s      = ST_DATA_ACK;
              end else if (addr_hit(byte_s, DEV_ADDR)) begin
                rw_nxt_s    = byte_s[0];
                state_nxt_s = ST_ADDR_ACK;
              end else begin
                state_nxt_s = ST_IGNORE;
              end
            end else begin
              state_nxt_s = state_r;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          // First scl fall (end of bit 8) pulls sda; second fall (end of bit 9) releases it.
          if (scl_fall_s) begin
            if (!ack_phase_r) begin
              sda_oe_nxt_s    = 1'b1;
              ack_phase_nxt_s = 1'b1;
            end else begin
              sda_oe_nxt_s    = 1'b0;
              ack_phase_nxt_s = 1'b0;
              if (state_r == ST_ADDR_ACK) begin
                addr_match_nxt_s = 1'b1;
                state_nxt_s      = rw_r ? ST_IGNORE : ST_DATA;
              end else begin
                state_nxt_s = ST_DATA;
              end
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= '0;
      shreg_r      <= 8'h00;
      ack_phase_r  <= 1'b0;
      sda_oe_r     <= 1'b0;
      start_det_r  <= 1'b0;
      stop_det_r   <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      rw_r         <= 1'b0;
      addr_match_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      shreg_r      <= shreg_nxt_s;
      ack_phase_r  <= ack_phase_nxt_s;
      sda_oe_r     <= sda_oe_nxt_s;
      start_det_r  <= start_det_nxt_s;
      stop_det_r   <= stop_det_nxt_s;
      byte_valid_r <= byte_valid_nxt_s;
      byte_data_r  <= byte_data_nxt_s;
      rw_r         <= rw_nxt_s;
      addr_match_r <= addr_match_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign bus.sda_oe     = sda_oe_r;
  assign bus.start_det  = start_det_r;
  assign bus.stop_det   = stop_det_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.byte_data  = byte_data_r;
  assign bus.rw         = rw_r;
  assign bus.addr_match = addr_match_r;
  assign bus.busy       = busy_r;
  assign bus.state_dbg  = state_r;

endmodule

// File: tb/tb_i2c_byte_rx.sv
// tb_i2c_byte_rx: directed bench for i2c_byte_rx, bit-banging an I2C master
// onto an open-drain sda model and checking events, bytes and ACK behaviour.
module tb_i2c_byte_rx;

  localparam int HALF = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic m_sda = 1'b1;
  logic m_scl = 1'b1;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n_start = 0;
  int n_stop  = 0;
  int n_bv    = 0;

  i2c_byte_rx_if bus ();

  assign bus.sda = m_sda & ~bus.sda_oe;
  assign bus.scl = m_scl;

  i2c_byte_rx #(.DEV_ADDR(7'h50), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Count one-cycle event pulses away from the active edge.
  always @(negedge clk) begin
    if (bus.start_det)  n_start <= n_start + 1;
    if (bus.stop_det)   n_stop  <= n_stop + 1;
    if (bus.byte_valid) n_bv    <= n_bv + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic oe_seen);
    m_sda = b;
    wait_cyc(HALF);
    m_scl = 1'b1;
    wait_cyc(HALF / 2);
    oe_seen = bus.sda_oe;
    wait_cyc(HALF / 2);
    m_scl = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    logic dummy;
    for (int i = 7; i > 7 - nbits; i--) send_bit(d[i], dummy);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    send_bits(d, 8);
    send_bit(1'b1, ack);
  endtask

  task automatic do_start();
    m_sda = 1'b1;
    wait_cyc(HALF);
    m_scl = 1'b1;
    wait_cyc(HALF);
    m_sda = 1'b0;
    wait_cyc(HALF);
    m_scl = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic do_stop();
    m_sda = 1'b0;
    wait_cyc(HALF);
    m_scl = 1'b1;
    wait_cyc(HALF);
    m_sda = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    int   s0, p0, b0;
    logic ack;

    // Reset values
    wait_cyc(4);
    check_val("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check_val("rst_state", 32'(bus.state_dbg), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_byte_data", 32'(bus.byte_data), 32'h00);
    check_val("rst_addr_match", 32'(bus.addr_match), 32'd0);
    reset = 1'b1;
    wait_cyc(4);

    // Write 0xA0, data 0x3C, STOP
    s0 = n_start; p0 = n_stop; b0 = n_bv;
    do_start();
    check_val("w_start_cnt", 32'(n_start - s0), 32'd1);
    check_val("w_busy", 32'(bus.busy), 32'd1);
    check_val("w_state_addr", 32'(bus.state_dbg), 32'd1);
    send_byte(8'hA0, ack);
    check_val("w_addr_ack", 32'(ack), 32'd1);
    check_val("w_addr_match", 32'(bus.addr_match), 32'd1);
    check_val("w_rw", 32'(bus.rw), 32'd0);
    check_val("w_state_data", 32'(bus.state_dbg), 32'd3);
    check_val("w_oe_released", 32'(bus.sda_oe), 32'd0);
    send_byte(8'h3C, ack);
    check_val("w_data_ack", 32'(ack), 32'd1);
    check_val("w_bv_cnt", 32'(n_bv - b0), 32'd1);
    check_val("w_byte_data", 32'(bus.byte_data), 32'h3C);
    do_stop();
    check_val("w_stop_cnt", 32'(n_stop - p0), 32'd1);
    check_val("w_busy_end", 32'(bus.busy), 32'd0);
    check_val("w_state_idle", 32'(bus.state_dbg), 32'd0);
    check_val("w_match_clr", 32'(bus.addr_match), 32'd0);

    // Wrong address 0xA2
    b0 = n_bv;
    do_start();
    send_byte(8'hA2, ack);
    check_val("na_ack", 32'(ack), 32'd0);
    check_val("na_state_ign", 32'(bus.state_dbg), 32'd5);
    send_byte(8'hFF, ack);
    check_val("na_data_ack", 32'(ack), 32'd0);
    check_val("na_bv_cnt", 32'(n_bv - b0), 32'd0);
    do_stop();
    check_val("na_state_idle", 32'(bus.state_dbg), 32'd0);

    // Read address 0xA1
    b0 = n_bv;
    do_start();
    send_byte(8'hA1, ack);
    check_val("rd_ack", 32'(ack), 32'd1);
    check_val("rd_rw", 32'(bus.rw), 32'd1);
    check_val("rd_state_ign", 32'(bus.state_dbg), 32'd5);
    check_val("rd_addr_match", 32'(bus.addr_match), 32'd1);
    check_val("rd_bv_cnt", 32'(n_bv - b0), 32'd0);
    do_stop();

    // Repeated START after 4 data bits
    do_start();
    send_byte(8'hA0, ack);
    check_val("rs_addr_ack", 32'(ack), 32'd1);
    b0 = n_bv; s0 = n_start;
    send_bits(8'hA5, 4);
    do_start();
    check_val("rs_start_cnt", 32'(n_start - s0), 32'd1);
    check_val("rs_bv_cnt", 32'(n_bv - b0), 32'd0);
    check_val("rs_state_addr", 32'(bus.state_dbg), 32'd1);
    check_val("rs_match_clr", 32'(bus.addr_match), 32'd0);
    check_val("rs_bit_cnt", 32'(dut.bit_cnt_r), 32'd0);
    send_byte(8'hA0, ack);
    check_val("rs_addr2_ack", 32'(ack), 32'd1);
    check_val("rs_state_data", 32'(bus.state_dbg), 32'd3);
    do_stop();

    // Reset while ACK is being driven
    do_start();
    send_bits(8'hA0, 8);
    check_val("ra_oe_set", 32'(bus.sda_oe), 32'd1);
    check_val("ra_state_ack", 32'(bus.state_dbg), 32'd2);
    m_sda = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check_val("ra_oe_clr", 32'(bus.sda_oe), 32'd0);
    check_val("ra_state_idle", 32'(bus.state_dbg), 32'd0);
    check_val("ra_busy", 32'(bus.busy), 32'd0);
    check_val("ra_byte_data", 32'(bus.byte_data), 32'h00);
    check_val("ra_sda_bus", 32'(bus.sda), 32'd1);
    reset = 1'b1;
    wait_cyc(HALF);
    m_scl = 1'b1;
    wait_cyc(HALF);

    // One-cycle low glitch on sda while scl is high
    s0 = n_start;
    m_sda = 1'b0;
    @(negedge clk);
    m_sda = 1'b1;
    wait_cyc(HALF);
`ifdef I2C_GLITCH_FILTER_EN
    check_val("gl_start_cnt", 32'(n_start - s0), 32'd0);
`else
    check_val("gl_start_cnt", 32'(n_start - s0), 32'd1);
`endif
    check_val("gl_state_idle", 32'(bus.state_dbg), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
